m_div_unit: RTL and testbench

Parametrised iterative integer divider for the M-extension unit, covering RISC-V DIV, DIVU, REM and REMU. It replaces the fixed 32-bit remainder/divisor/quotient register block with a complete unit: its own control FSM, a start/done handshake, signed/unsigned sign handling, RISC-V corner-case results and flush support. It sits beside the multiplier in the M unit, driven by the M-unit decode logic, and returns a registered XLEN-bit result.

---
 rtl/m_div_unit_pkg.sv | 9 +
 rtl/m_div_unit_if.sv | 16 +
 rtl/m_div_unit_datapath.sv | 36 +++
 rtl/m_div_unit.sv | 111 +++++++++++
 tb/tb_m_div_unit.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/m_div_unit_pkg.sv
// rtl/m_div_unit_pkg.sv - shared types for the M-unit iterative divider
package m_div_pkg;
   typedef enum logic [1:0] {DIV = 2'd0, DIVU = 2'd1, REM = 2'd2, REMU = 2'd3} div_op_t;
   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

   function automatic int cnt_width(input int xlen);
      return $clog2(xlen);
   endfunction
endpackage

// File: rtl/m_div_unit_if.sv
// rtl/m_div_unit_if.sv - request/response bundle between M-unit decode and the divider
interface m_div_unit_if #(parameter int XLEN = 32);
   import m_div_pkg::*;

   logic            start;
   div_op_t         op;
   logic [XLEN-1:0] rs1;
   logic [XLEN-1:0] rs2;
   logic            flush;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (output start, op, rs1, rs2, flush, input busy, done, result);
   modport slave  (input start, op, rs1, rs2, flush, output busy, done, result);
endinterface

// File: rtl/m_div_unit_datapath.sv
// rtl/m_div_unit_datapath.sv - restoring-division remainder/divisor/quotient registers
module m_div_datapath #(parameter int XLEN = 32) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            load,
   input  logic            step,
   input  logic [XLEN-1:0] r_init,
   input  logic [XLEN-1:0] d_init,
   output logic [XLEN-1:0] r,
   output logic [XLEN-1:0] z,
   output logic            borrow
);
   logic [2*XLEN-2:0] d;
   logic [2*XLEN-1:0] diff;

   assign diff = {{XLEN{1'b0}}, r} - {1'b0, d};
   // Without a borrow the difference never exceeds R, so any set bit above XLEN-1 means a borrow.
   assign borrow = |diff[2*XLEN-1:XLEN];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r <= '0;
         d <= '0;
         z <= '0;
      end else if (load) begin
         r <= r_init;
         d <= {d_init, {(XLEN-1){1'b0}}};
         z <= '0;
      end else if (step) begin
         if (!borrow)
            r <= diff[XLEN-1:0];
         z <= {z[XLEN-2:0], ~borrow};
         d <= d >> 1;
      end
   end
endmodule

// File: rtl/m_div_unit.sv
// rtl/m_div_unit.sv - iterative DIV/DIVU/REM/REMU unit: control FSM, corner cases, sign fix
module m_div_unit #(parameter int XLEN = 32) (
   input  logic         clk,
   input  logic         resetn,
   m_div_unit_if.slave  dif
);
   import m_div_pkg::*;

   localparam int CW = cnt_width(XLEN);

   state_t          state;
   div_op_t         op_q;
   logic            s1_q, s2_q, busy_q, done_q;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] result_q;

   logic            signed_in, quot_in, div_zero, sgn_ovf, special, accept, load;
   logic [XLEN-1:0] mag1, mag2, spec_res, r, z, q_fix, r_fix;
   logic            borrow;

   always_comb begin
      signed_in = (dif.op == DIV) || (dif.op == REM);
      quot_in   = (dif.op == DIV) || (dif.op == DIVU);
      mag1      = (signed_in && dif.rs1[XLEN-1]) ? -dif.rs1 : dif.rs1;
      mag2      = (signed_in && dif.rs2[XLEN-1]) ? -dif.rs2 : dif.rs2;
      div_zero  = (dif.rs2 == '0);
      sgn_ovf   = signed_in && (dif.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (dif.rs2 == '1);
      special   = div_zero || sgn_ovf;
      if (div_zero)
         spec_res = quot_in ? '1 : dif.rs1;
      else
         spec_res = quot_in ? dif.rs1 : '0;
      accept = (state == IDLE) && dif.start && !dif.flush;
      load   = accept && !special;
      q_fix  = ((op_q == DIV) && (s1_q ^ s2_q)) ? -z : z;
      r_fix  = ((op_q == REM) && s1_q) ? -r : r;
   end

   m_div_datapath #(.XLEN(XLEN)) u_datapath (
      .clk    (clk),
      .resetn (resetn),
      .load   (load),
      .step   (state == CALC),
      .r_init (mag1),
      .d_init (mag2),
      .r      (r),
      .z      (z),
      .borrow (borrow)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         op_q     <= DIV;
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         cnt      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  op_q   <= dif.op;
                  s1_q   <= signed_in && dif.rs1[XLEN-1];
                  s2_q   <= signed_in && dif.rs2[XLEN-1];
                  cnt    <= CW'(XLEN-1);
                  busy_q <= 1'b1;
                  if (special) begin
                     state    <= DONE;
                     done_q   <= 1'b1;
                     result_q <= spec_res;
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               if (dif.flush) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end else if (cnt == '0) begin
                  state <= FIX;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            FIX: begin
               if (dif.flush) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end else begin
                  state    <= DONE;
                  done_q   <= 1'b1;
                  result_q <= ((op_q == DIV) || (op_q == DIVU)) ? q_fix : r_fix;
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign dif.busy   = busy_q;
   assign dif.done   = done_q;
   assign dif.result = result_q;
endmodule

// File: tb/tb_m_div_unit.sv
// tb/tb_m_div_unit.sv - bench for m_div_unit at XLEN=32 and XLEN=8
module tb_m_div_unit;
   import m_div_pkg::*;

   logic clk = 1'b0;
   logic resetn;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   m_div_unit_if #(.XLEN(32)) dif32();
   m_div_unit_if #(.XLEN(8))  dif8();

   m_div_unit #(.XLEN(32)) u_div32 (.clk(clk), .resetn(resetn), .dif(dif32));
   m_div_unit #(.XLEN(8))  u_div8  (.clk(clk), .resetn(resetn), .dif(dif8));

   typedef struct {
      int          xlen;
      div_op_t     op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t tbl[16];

   task automatic chk(input string name, input longint act, input longint exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic is_special(input int xlen, input div_op_t op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      if (b == 0) return 1'b1;
      if (op == DIVU || op == REMU) return 1'b0;
      sa = a[xlen-1] ? longint'(a) - (longint'(1) << xlen) : longint'(a);
      sb = b[xlen-1] ? longint'(b) - (longint'(1) << xlen) : longint'(b);
      return (sa == -(longint'(1) << (xlen-1))) && (sb == -1);
   endfunction

   // Reference: plain integer arithmetic with RISC-V rules (truncating division).
   function automatic logic [31:0] ref_res(input int xlen, input div_op_t op, input logic [31:0] a, input logic [31:0] b);
      longint mask, sa, sb, q, r;
      logic quot;
      mask = (longint'(1) << xlen) - 1;
      quot = (op == DIV) || (op == DIVU);
      if (b == 0) return quot ? 32'(mask) : a;
      if (op == DIV || op == REM) begin
         sa = a[xlen-1] ? longint'(a) - (longint'(1) << xlen) : longint'(a);
         sb = b[xlen-1] ? longint'(b) - (longint'(1) << xlen) : longint'(b);
         if (sa == -(longint'(1) << (xlen-1)) && sb == -1) return quot ? a : 32'd0;
      end else begin
         sa = longint'(a);
         sb = longint'(b);
      end
      q = sa / sb;
      r = sa % sb;
      return quot ? 32'(q & mask) : 32'(r & mask);
   endfunction

   task automatic run32(input div_op_t op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int busy_cyc);
      @(negedge clk);
      dif32.op = op; dif32.rs1 = a; dif32.rs2 = b; dif32.start = 1'b1;
      @(posedge clk);
      #1 dif32.start = 1'b0;
      lat = 0; busy_cyc = 0;
      repeat (100) begin
         @(negedge clk);
         lat++;
         if (dif32.done) break;
         if (dif32.busy) busy_cyc++;
      end
      res = dif32.result;
   endtask

   task automatic run8(input div_op_t op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int busy_cyc);
      @(negedge clk);
      dif8.op = op; dif8.rs1 = a[7:0]; dif8.rs2 = b[7:0]; dif8.start = 1'b1;
      @(posedge clk);
      #1 dif8.start = 1'b0;
      lat = 0; busy_cyc = 0;
      repeat (100) begin
         @(negedge clk);
         lat++;
         if (dif8.done) break;
         if (dif8.busy) busy_cyc++;
      end
      res = {24'd0, dif8.result};
   endtask

   task automatic run_check(input string tag, input int xlen, input div_op_t op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp, input int exp_lat);
      logic [31:0] res;
      int lat, bc;
      if (xlen == 8) run8(op, a, b, res, lat, bc);
      else run32(op, a, b, res, lat, bc);
      chk($sformatf("%s result op=%0d a=%0h b=%0h", tag, op, a, b), res, exp);
      chk($sformatf("%s latency op=%0d a=%0h b=%0h", tag, op, a, b), lat, exp_lat);
      chk($sformatf("%s busy cycles op=%0d", tag, op), bc, exp_lat - 1);
   endtask

   function automatic logic [31:0] pick(input int xlen);
      logic [31:0] mask, v;
      mask = (xlen == 8) ? 32'hFF : 32'hFFFF_FFFF;
      case ($urandom_range(0, 7))
         0: v = 32'd0;
         1: v = 32'd1;
         2: v = 32'hFFFF_FFFF;
         3: v = 32'd1 << (xlen-1);
         4: v = 32'($urandom_range(1, 20));
         default: v = $urandom;
      endcase
      return v & mask;
   endfunction

   initial begin
      logic [31:0] res, a, b;
      div_op_t op;
      int lat, bc, dones;

      tbl[0]  = '{32, DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34};
      tbl[1]  = '{32, REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34};
      tbl[2]  = '{32, DIVU, 32'd100,       32'd7,         32'd14,        34};
      tbl[3]  = '{32, REMU, 32'd100,       32'd7,         32'd2,         34};
      tbl[4]  = '{32, DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 1};
      tbl[5]  = '{32, REMU, 32'd5,         32'd0,         32'd5,         1};
      tbl[6]  = '{32, DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
      tbl[7]  = '{32, REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
      tbl[8]  = '{32, DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         34};
      tbl[9]  = '{32, REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34};
      tbl[10] = '{32, REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         34};
      tbl[11] = '{32, DIV,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         34};
      tbl[12] = '{8,  DIVU, 32'hFF,        32'h01,        32'hFF,        10};
      tbl[13] = '{8,  DIV,  32'h80,        32'h03,        32'hD6,        10};
      tbl[14] = '{8,  REM,  32'h80,        32'h03,        32'hFE,        10};
      tbl[15] = '{8,  DIV,  32'h80,        32'hFF,        32'h80,        1};

      resetn = 1'b0;
      dif32.start = 1'b0; dif32.flush = 1'b0; dif32.op = DIV; dif32.rs1 = '0; dif32.rs2 = '0;
      dif8.start  = 1'b0; dif8.flush  = 1'b0; dif8.op  = DIV; dif8.rs1  = '0; dif8.rs2  = '0;
      repeat (3) @(negedge clk);
      chk("reset busy", dif32.busy, 0);
      chk("reset done", dif32.done, 0);
      chk("reset result", dif32.result, 0);
      chk("reset result8", dif8.result, 0);
      resetn = 1'b1;

      foreach (tbl[i])
         run_check($sformatf("tbl%0d", i), tbl[i].xlen, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat);

      for (int i = 0; i < 60; i++) begin
         int xl;
         xl = (i % 2 == 0) ? 32 : 8;
         op = div_op_t'($urandom_range(0, 3));
         a = pick(xl);
         b = pick(xl);
         run_check($sformatf("rand%0d x%0d", i, xl), xl, op, a, b, ref_res(xl, op, a, b),
                   is_special(xl, op, a, b) ? 1 : xl + 2);
      end

      // Flush mid-CALC: no done, result keeps the previous value.
      run_check("pre-flush", 32, DIVU, 32'd10, 32'd3, 32'd3, 34);
      @(negedge clk);
      dif32.op = DIVU; dif32.rs1 = 32'd1000; dif32.rs2 = 32'd3; dif32.start = 1'b1;
      @(posedge clk);
      #1 dif32.start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      dif32.flush = 1'b1;
      @(posedge clk);
      #1 dif32.flush = 1'b0;
      @(negedge clk);
      chk("flush busy", dif32.busy, 0);
      chk("flush result held", dif32.result, 3);
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (dif32.done) dones++;
      end
      chk("flush no done", dones, 0);
      run_check("post-flush", 32, DIVU, 32'd1000, 32'd3, 32'd333, 34);

      // Second start while busy is ignored.
      @(negedge clk);
      dif32.op = DIVU; dif32.rs1 = 32'd100; dif32.rs2 = 32'd7; dif32.start = 1'b1;
      @(posedge clk);
      #1 dif32.start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      dif32.op = DIVU; dif32.rs1 = 32'd50; dif32.rs2 = 32'd5; dif32.start = 1'b1;
      @(posedge clk);
      #1 dif32.start = 1'b0;
      dones = 0; res = '0;
      repeat (60) begin
         @(negedge clk);
         if (dif32.done) begin
            dones++;
            res = dif32.result;
         end
      end
      chk("busy start done count", dones, 1);
      chk("busy start result", res, 14);

      // Asynchronous reset mid-CALC.
      @(negedge clk);
      dif32.op = DIVU; dif32.rs1 = 32'd1000; dif32.rs2 = 32'd3; dif32.start = 1'b1;
      @(posedge clk);
      #1 dif32.start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("midreset busy", dif32.busy, 0);
      chk("midreset done", dif32.done, 0);
      chk("midreset result", dif32.result, 0);
      @(negedge clk);
      resetn = 1'b1;
      run_check("post-reset", 32, DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
